// File: rtl/fifo_read_arbiter_pkg.sv
// Shared types and width helpers for the FIFO read-side arbiter.
package fifo_read_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_N_REQ     = 4;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_ID_W      = $clog2(DEF_N_REQ);
  localparam int DEF_CNT_W     = $clog2(DEF_MAX_BURST) + 1;

  // Burst counter width; wide enough to hold max_burst-1 even when max_burst is 1.
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// Consumer/FIFO-facing bus of the read arbiter; slave = arbiter side.
interface fifo_read_arbiter_if
  import fifo_read_arbiter_pkg::*;
#(
  parameter int width    = DEF_WIDTH,
  parameter int n_req    = DEF_N_REQ,
  parameter int id_width = $clog2(n_req)
);
  logic [n_req-1:0]    req;
  logic                FIFO_empty;
  logic [width-1:0]    rd_data;
  logic                rd_en;
  logic [n_req-1:0]    gnt;
  logic [width-1:0]    dout;
  logic                dout_valid;
  logic [id_width-1:0] dout_id;

  modport slave (
    input  req, FIFO_empty, rd_data,
    output rd_en, gnt, dout, dout_valid, dout_id
  );

  modport master (
    output req, FIFO_empty, rd_data,
    input  rd_en, gnt, dout, dout_valid, dout_id
  );
endinterface

// File: rtl/fifo_read_arbiter_rr_picker.sv
// Combinational round-robin selector: first set req searching upward from last+1.
module rr_picker
  import fifo_read_arbiter_pkg::*;
#(
  parameter int n_req    = DEF_N_REQ,
  parameter int id_width = $clog2(n_req)
) (
  input  logic [n_req-1:0]    req,
  input  logic [id_width-1:0] last,
  output logic [n_req-1:0]    win,
  output logic [id_width-1:0] idx,
  output logic                any
);

  logic [id_width-1:0] k;

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    // Offset n_req revisits last itself, so a lone requester is re-granted.
    for (int i = 1; i <= n_req; i++) begin
      k = id_width'((int'(last) + i) % n_req);
      if (!any && req[k]) begin
        any    = 1'b1;
        win[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Shares the FIFO read port among n_req consumers: round-robin grants, bursts of up to max_burst words.
module fifo_read_arbiter
  import fifo_read_arbiter_pkg::*;
#(
  parameter int width     = DEF_WIDTH,
  parameter int n_req     = DEF_N_REQ,
  parameter int max_burst = DEF_MAX_BURST,
  parameter int id_width  = $clog2(n_req)
) (
  input logic               clk_r,
  input logic               reset,
  fifo_read_arbiter_if.slave bus
);

  localparam int CW = cnt_w(max_burst);

  state_e              state_q, state_d;
  logic [n_req-1:0]    gnt_q, gnt_d;
  logic [id_width-1:0] owner_q, owner_d;
  logic [id_width-1:0] last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [width-1:0]    dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic [id_width-1:0] dout_id_q, dout_id_d;

  logic                rd_en;
  logic [n_req-1:0]    pick_win;
  logic [id_width-1:0] pick_idx;
  logic                pick_any;

  rr_picker #(.n_req(n_req), .id_width(id_width)) u_picker (
    .req  (bus.req),
    .last (last_q),
    .win  (pick_win),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk_r or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      last_q       <= id_width'(n_req - 1);
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_id_q    <= dout_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_any && !bus.FIFO_empty) begin
          state_d = BURST;
          gnt_d   = pick_win;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        // Request drop wins over an empty stall; empty alone only freezes the count.
        if (!bus.req[owner_q] || (rd_en && cnt_q == CW'(max_burst - 1))) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (rd_en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rd_en = (state_q == BURST) && bus.req[owner_q] && !bus.FIFO_empty;
  end

  // rd_data is sampled on the edge that closes the rd_en cycle.
  always_comb begin
    dout_valid_d = rd_en;
    dout_d       = rd_en ? bus.rd_data : dout_q;
    dout_id_d    = rd_en ? owner_q     : dout_id_q;
  end

  assign bus.rd_en      = rd_en;
  assign bus.gnt        = gnt_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_id    = dout_id_q;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter: FIFO modelled as a word counter with incrementing data.
module tb_fifo_read_arbiter;

  logic clk_r = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   pushed = 0;
  int   popped = 0;
  logic hold_empty = 1'b0;
  int   k;

  bit en1 [8] = '{1, 1, 1, 1, 0, 1, 1, 0};
  bit vl1 [8] = '{0, 1, 1, 1, 1, 0, 1, 1};
  bit gn1 [8] = '{1, 1, 1, 1, 0, 1, 1, 1};
  int own2 [5] = '{1, 2, 3, 0, 1};

  fifo_read_arbiter_if #(.width(32), .n_req(4), .id_width(2)) bus ();

  fifo_read_arbiter #(.width(32), .n_req(4), .max_burst(4), .id_width(2)) dut (
    .clk_r (clk_r),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk_r = ~clk_r;

  assign bus.FIFO_empty = (pushed == popped) || hold_empty;
  assign bus.rd_data    = 32'hD000_0000 + 32'(popped);

  always @(posedge clk_r) if (bus.rd_en) popped <= popped + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk_r);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_r);
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  initial begin
    bus.req = 4'b0000;
    // reset state
    go(); mid();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_dout_id", bus.dout_id, 0);
    reset = 1'b1;

    // single requester, 6 words: 4-word burst, bubble, 2 words, stall on empty
    go(); bus.req = 4'b0001; pushed = 6; mid();
    chk("t1_idle_gnt", bus.gnt, 0);
    k = 0;
    for (int c = 0; c < 8; c++) begin
      go(); mid();
      chk("t1_rd_en", bus.rd_en, en1[c]);
      chk("t1_gnt", bus.gnt, gn1[c] ? 4'b0001 : 4'b0000);
      chk("t1_dout_valid", bus.dout_valid, vl1[c]);
      if (vl1[c]) begin
        chk("t1_dout", bus.dout, 32'hD000_0000 + 32'(k));
        chk("t1_dout_id", bus.dout_id, 0);
        k++;
      end
    end
    go(); bus.req = 4'b0000; mid();
    chk("t1_stall_gnt", bus.gnt, 4'b0001);
    chk("t1_drop_rd_en", bus.rd_en, 0);
    go(); mid();
    chk("t1_release_gnt", bus.gnt, 0);

    // full contention, last winner 0: grants 1,2,3,0,1 with one bubble between bursts
    go(); bus.req = 4'b1111; pushed = 106; mid();
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 4; w++) begin
        go(); mid();
        chk("t2_gnt", bus.gnt, oh(own2[b]));
        chk("t2_rd_en", bus.rd_en, 1);
        if (w == 1) chk("t2_dout_id", bus.dout_id, own2[b]);
      end
      go(); if (b == 4) bus.req = 4'b0000; mid();
      chk("t2_bubble_gnt", bus.gnt, 0);
      chk("t2_bubble_rd_en", bus.rd_en, 0);
    end

    // empty stall: owner 2 reads 1 word, FIFO empty 3 cycles, then 3 more words
    go(); bus.req = 4'b0100; mid();
    go(); mid();
    chk("t3_gnt", bus.gnt, 4'b0100);
    chk("t3_rd_en_first", bus.rd_en, 1);
    for (int s = 0; s < 3; s++) begin
      go(); hold_empty = 1'b1; mid();
      chk("t3_stall_gnt", bus.gnt, 4'b0100);
      chk("t3_stall_rd_en", bus.rd_en, 0);
    end
    go(); hold_empty = 1'b0; mid();
    chk("t3_resume_rd_en", bus.rd_en, 1);
    go(); mid();
    chk("t3_rd_en_3", bus.rd_en, 1);
    go(); mid();
    chk("t3_rd_en_4", bus.rd_en, 1);
    chk("t3_gnt_4", bus.gnt, 4'b0100);
    go(); bus.req = 4'b0000; mid();
    chk("t3_exit_gnt", bus.gnt, 0);
    chk("t3_exit_rd_en", bus.rd_en, 0);
    chk("t3_dout_id", bus.dout_id, 2);

    // early release: owner 1 drops after 2 reads, requester 2 next
    go(); bus.req = 4'b0110; mid();
    go(); mid();
    chk("t4_gnt", bus.gnt, 4'b0010);
    go(); mid();
    chk("t4_rd_en_2", bus.rd_en, 1);
    go(); bus.req = 4'b0100; mid();
    chk("t4_drop_gnt", bus.gnt, 4'b0010);
    chk("t4_drop_rd_en", bus.rd_en, 0);
    go(); mid();
    chk("t4_idle_gnt", bus.gnt, 0);
    go(); mid();
    chk("t4_next_gnt", bus.gnt, 4'b0100);

    // wrap-around: make 3 the last winner, then req 0101 grants 0 then 2
    go(); bus.req = 4'b1000; mid();
    chk("t5_drop_rd_en", bus.rd_en, 0);
    go(); mid();
    go(); mid();
    chk("t5_gnt3", bus.gnt, 4'b1000);
    go(); bus.req = 4'b0101; mid();
    go(); mid();
    chk("t5_idle_gnt", bus.gnt, 0);
    go(); mid();
    chk("t5_gnt0", bus.gnt, 4'b0001);
    go(); mid();
    chk("t5_dout_id0", bus.dout_id, 0);
    go(); mid();
    go(); mid();
    chk("t5_rd_en_4", bus.rd_en, 1);
    go(); mid();
    chk("t5_bubble_gnt", bus.gnt, 0);
    go(); mid();
    chk("t5_gnt2", bus.gnt, 4'b0100);
    chk("t5_rd_en_gnt2", bus.rd_en, 1);

    // reset during word 2 of owner 2's burst
    go(); mid();
    chk("t6_word2_rd_en", bus.rd_en, 1);
    #1 reset = 1'b0; bus.req = 4'b1000;
    #1;
    chk("t6_rst_gnt", bus.gnt, 0);
    chk("t6_rst_rd_en", bus.rd_en, 0);
    chk("t6_rst_dout_valid", bus.dout_valid, 0);
    chk("t6_rst_dout", bus.dout, 0);
    go(); mid();
    reset = 1'b1;
    go(); mid();
    chk("t6_gnt3", bus.gnt, 4'b1000);
    chk("t6_rd_en", bus.rd_en, 1);
    chk("t6_no_stale_valid", bus.dout_valid, 0);
    go(); bus.req = 4'b0000; mid();
    chk("t6_dout_valid", bus.dout_valid, 1);
    chk("t6_dout_id", bus.dout_id, 3);
    go(); mid();
    go(); mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
